// File: rtl/hp35_ctc_rom_port.sv
// hp35_ctc_rom_port: calculator-side word-time generator and serial ROM port.
// Produces the word framing, the sync strobe and the serial address, and
// collects the serial instruction returned by the ROM during sync.
module hp35_ctc_rom_port #(
    parameter int WORD_BITS  = 56,
    parameter int ADDR_START = 19,
    parameter int SYNC_START = 45
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic       is_in,
    output logic       sync,
    output logic       ia,
    output logic [5:0] bit_time,
    output logic [9:0] instr,
    output logic       instr_valid
);

    // Bit-time decode points. Outputs are registered, so each field is
    // decoded one bit time early and lands on the flop at the right time.
    localparam logic [5:0] LAST_BT    = 6'(WORD_BITS - 1);
    localparam logic [5:0] ADDR_LOAD  = 6'(ADDR_START - 1);
    localparam logic [5:0] ADDR_FIRST = 6'(ADDR_START);
    localparam logic [5:0] ADDR_LAST  = 6'(ADDR_START + 7);
    localparam logic [5:0] SYNC_PRE   = 6'(SYNC_START - 1);
    localparam logic [5:0] SYNC_PRE_L = 6'(SYNC_START + 8);
    localparam logic [5:0] SYNC_FIRST = 6'(SYNC_START);
    localparam logic [5:0] SYNC_LAST  = 6'(SYNC_START + 9);

    logic [7:0] addr_sr;
    logic [9:0] instr_sr;

    // Free-running bit-time counter, wraps at the end of the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  bit_time <= 6'd0;
        else if (bit_time == LAST_BT) bit_time <= 6'd0;
        else                        bit_time <= bit_time + 6'd1;
    end

    // Sync strobe: set for the ten bit times of the instruction field.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= 1'b0;
        else       sync <= (bit_time >= SYNC_PRE) && (bit_time <= SYNC_PRE_L);
    end

    // Address serializer: latch addr just before the field, then shift LSB first.
    // ia mirrors addr_sr[0] during the field; it is loaded with the bit that
    // will be in addr_sr[0] after this edge so no combinational path exists.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_sr <= 8'h00;
            ia      <= 1'b0;
        end else if (bit_time == ADDR_LOAD) begin
            addr_sr <= addr;
            ia      <= addr[0];
        end else if ((bit_time >= ADDR_FIRST) && (bit_time <= ADDR_LAST)) begin
            addr_sr <= {1'b0, addr_sr[7:1]};
            ia      <= (bit_time != ADDR_LAST) && addr_sr[1];
        end else begin
            ia      <= 1'b0;
        end
    end

    // Instruction deserializer: first bit received ends up in bit 0; the
    // completed word is published with a one-bit-time valid strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_sr    <= 10'h000;
            instr       <= 10'h000;
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            if ((bit_time >= SYNC_FIRST) && (bit_time <= SYNC_LAST)) begin
                instr_sr <= {is_in, instr_sr[9:1]};
                if (bit_time == SYNC_LAST) begin
                    instr       <= {is_in, instr_sr[9:1]};
                    instr_valid <= 1'b1;
                end
            end
        end
    end

endmodule
